// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller for the RK2040 core: synchronises raw lines, latches falling edges,
// and runs a req/ack/return handshake. Define INT_NESTING_EN to let higher-priority lines preempt service.
module interrupt_controller #(
    parameter int                   NUM_IRQ       = 8,
    parameter int                   VEC_WIDTH     = 8,
    parameter logic [VEC_WIDTH-1:0] VECTOR_BASE   = 8'h80,
    parameter int                   VECTOR_STRIDE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irqIn,
    input  logic                 maskWe,
    input  logic [NUM_IRQ-1:0]   maskIn,
    input  logic                 cpuAck,
    input  logic                 retI,
    output logic                 cpuReq,
    output logic [2:0]           irqId,
    output logic [VEC_WIDTH-1:0] irqVector,
    output logic [NUM_IRQ-1:0]   irqMask,
    output logic [NUM_IRQ-1:0]   pending,
    output logic [NUM_IRQ-1:0]   inService
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } stateType;

    stateType state, nextState;

    logic [NUM_IRQ-1:0] syncA, syncB, edgeHist;
    logic [NUM_IRQ-1:0] fallEdge, eligible;
    logic [NUM_IRQ-1:0] ackSet, retClr;
    logic [2:0]         eligIdx, svcIdx;
    logic               latchReq, doAck, doRet;

    // Highest set index wins; returns 0 for an empty vector (callers gate on non-zero).
    function automatic logic [2:0] highestIdx(input logic [NUM_IRQ-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [VEC_WIDTH-1:0] vectorOf(input logic [2:0] id);
        return VECTOR_BASE + VEC_WIDTH'(VECTOR_STRIDE * int'(id));
    endfunction

    // Stage boundary: two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncA    <= '0;
            syncB    <= '0;
            edgeHist <= '0;
        end else begin
            syncA    <= irqIn;
            syncB    <= syncA;
            edgeHist <= syncB;
        end
    end

    assign fallEdge = edgeHist & ~syncB;
    assign eligible = pending & irqMask;
    assign eligIdx  = highestIdx(eligible);
    assign svcIdx   = highestIdx(inService);
    assign ackSet   = doAck ? (NUM_IRQ'(1) << irqId) : '0;
    assign retClr   = doRet ? (NUM_IRQ'(1) << svcIdx) : '0;

    always_comb begin
        nextState = state;
        latchReq  = 1'b0;
        doAck     = 1'b0;
        doRet     = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    nextState = REQ;
                    latchReq  = 1'b1;
                end
            end
            REQ: begin
                if (cpuAck) begin
                    nextState = SERVICE;
                    doAck     = 1'b1;
                end
            end
            SERVICE: begin
                if (retI) begin
                    doRet = 1'b1;
                    if ((inService & ~(NUM_IRQ'(1) << svcIdx)) == '0) nextState = IDLE;
                end
`ifdef INT_NESTING_EN
                else if (eligible != '0 && eligIdx > svcIdx) begin
                    nextState = REQ;
                    latchReq  = 1'b1;
                end
`endif
            end
            default: nextState = IDLE;
        endcase
    end

    // Stage boundary: FSM, request/vector latch, pending/in-service bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cpuReq    <= 1'b0;
            irqId     <= '0;
            irqVector <= '0;
            irqMask   <= '0;
            pending   <= '0;
            inService <= '0;
        end else begin
            state <= nextState;
            if (latchReq) begin
                cpuReq    <= 1'b1;
                irqId     <= eligIdx;
                irqVector <= vectorOf(eligIdx);
            end else if (doAck) begin
                cpuReq <= 1'b0;
            end
            if (maskWe) irqMask <= maskIn;
            // A new edge on the line being acknowledged keeps it pending.
            pending   <= (pending & ~ackSet) | fallEdge;
            inService <= (inService | ackSet) & ~retClr;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomized
// falls/masks served in priority order and compared against a plain bit-level model.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irqIn;
    logic       maskWe;
    logic [7:0] maskIn;
    logic       cpuAck;
    logic       retI;
    logic       cpuReq;
    logic [2:0] irqId;
    logic [7:0] irqVector;
    logic [7:0] irqMask;
    logic [7:0] pending;
    logic [7:0] inService;

    int passed = 0;
    int total  = 0;

    interrupt_controller dut (
        .clk       (clk),
        .rst       (rst),
        .irqIn     (irqIn),
        .maskWe    (maskWe),
        .maskIn    (maskIn),
        .cpuAck    (cpuAck),
        .retI      (retI),
        .cpuReq    (cpuReq),
        .irqId     (irqId),
        .irqVector (irqVector),
        .irqMask   (irqMask),
        .pending   (pending),
        .inService (inService)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: time limit reached, got still running want finished");
        $fatal(1, "watchdog");
    end

    // Reference rules: highest pending+enabled index wins, vector = 0x80 + 4*id.
    function automatic int modelId(input logic [7:0] v);
        int id;
        id = -1;
        for (int i = 0; i < 8; i++) if (v[i]) id = i;
        return id;
    endfunction

    function automatic logic [7:0] modelVec(input int id);
        return 8'(8'h80 + id * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic ack();
        cpuAck = 1'b1;
        tick();
        cpuAck = 1'b0;
    endtask

    task automatic ret();
        retI = 1'b1;
        tick();
        retI = 1'b0;
    endtask

    task automatic setMask(input logic [7:0] m);
        maskWe = 1'b1;
        maskIn = m;
        tick();
        maskWe = 1'b0;
    endtask

    // Raise the chosen lines long enough to settle, then drop them; returns at the fall.
    task automatic fall(input logic [7:0] b);
        irqIn = irqIn | b;
        ticks(4);
        irqIn = irqIn & ~b;
    endtask

    task automatic test_reset();
        rst = 1'b1; irqIn = '0; maskWe = 1'b0; maskIn = '0; cpuAck = 1'b0; retI = 1'b0;
        #20;
        total++; if ({cpuReq, irqId, irqVector} !== 12'h0) $display("FAIL reset_req: got %b/%h/%h want 0/0/00", cpuReq, irqId, irqVector); else passed++;
        total++; if ({irqMask, pending, inService} !== 24'h0) $display("FAIL reset_regs: got %h/%h/%h want 00/00/00", irqMask, pending, inService); else passed++;
        #20 rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        setMask(8'hFF);
        fall(8'h20);
        ticks(2);
        total++; if (pending !== 8'h00) $display("FAIL single_early: got pending %h want 00", pending); else passed++;
        tick();
        total++; if (pending !== 8'h20 || cpuReq !== 1'b0) $display("FAIL single_pend: got %h/%b want 20/0", pending, cpuReq); else passed++;
        tick();
        total++; if ({cpuReq, irqId, irqVector} !== {1'b1, 3'd5, 8'h94}) $display("FAIL single_req: got %b/%0d/%h want 1/5/94", cpuReq, irqId, irqVector); else passed++;
        ack();
        total++; if ({cpuReq, pending, inService} !== {1'b0, 8'h00, 8'h20}) $display("FAIL single_ack: got %b/%h/%h want 0/00/20", cpuReq, pending, inService); else passed++;
        ret();
        tick();
        total++; if ({cpuReq, inService} !== 9'h0) $display("FAIL single_ret: got %b/%h want 0/00", cpuReq, inService); else passed++;
    endtask

    task automatic test_priority();
        fall(8'hA0);
        ticks(4);
        total++; if ({cpuReq, irqId, irqVector} !== {1'b1, 3'd7, 8'h9C}) $display("FAIL prio_first: got %b/%0d/%h want 1/7/9c", cpuReq, irqId, irqVector); else passed++;
        ack();
        ret();
        total++; if (cpuReq !== 1'b0 || pending !== 8'h20) $display("FAIL prio_gap: got %b/%h want 0/20", cpuReq, pending); else passed++;
        tick();
        total++; if ({cpuReq, irqId, irqVector} !== {1'b1, 3'd5, 8'h94}) $display("FAIL prio_second: got %b/%0d/%h want 1/5/94", cpuReq, irqId, irqVector); else passed++;
        ack();
        ret();
        tick();
    endtask

    task automatic test_req_hold();
        fall(8'h20);
        ticks(4);
        fall(8'h80);
        ticks(4);
        total++; if ({cpuReq, irqId, pending} !== {1'b1, 3'd5, 8'hA0}) $display("FAIL hold_id: got %b/%0d/%h want 1/5/a0", cpuReq, irqId, pending); else passed++;
        setMask(8'h00);
        tick();
        total++; if ({cpuReq, irqId} !== {1'b1, 3'd5}) $display("FAIL hold_mask: got %b/%0d want 1/5", cpuReq, irqId); else passed++;
        ack();
        total++; if ({pending, inService} !== 16'h8020) $display("FAIL hold_ack: got %h/%h want 80/20", pending, inService); else passed++;
        setMask(8'hFF);
        ret();
        tick();
        total++; if ({cpuReq, irqId} !== {1'b1, 3'd7}) $display("FAIL hold_next: got %b/%0d want 1/7", cpuReq, irqId); else passed++;
        ack();
        ret();
        tick();
        ack();
        total++; if ({cpuReq, inService} !== 9'h0) $display("FAIL stray_ack: got %b/%h want 0/00", cpuReq, inService); else passed++;
        ret();
        total++; if ({cpuReq, pending, inService} !== 17'h0) $display("FAIL stray_ret: got %b/%h/%h want 0/00/00", cpuReq, pending, inService); else passed++;
    endtask

    task automatic test_mask();
        setMask(8'h7F);
        total++; if (irqMask !== 8'h7F) $display("FAIL mask_write: got %h want 7f", irqMask); else passed++;
        fall(8'h80);
        ticks(5);
        total++; if (pending !== 8'h80 || cpuReq !== 1'b0) $display("FAIL mask_block: got %h/%b want 80/0", pending, cpuReq); else passed++;
        setMask(8'hFF);
        total++; if (cpuReq !== 1'b0) $display("FAIL mask_delay: got %b want 0", cpuReq); else passed++;
        tick();
        total++; if ({cpuReq, irqId} !== {1'b1, 3'd7}) $display("FAIL mask_enable: got %b/%0d want 1/7", cpuReq, irqId); else passed++;
        ack();
        ret();
        tick();
    endtask

    task automatic test_held_reset();
        irqIn = 8'h08;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(6);
        total++; if (pending !== 8'h00) $display("FAIL held_noedge: got %h want 00", pending); else passed++;
        irqIn = 8'h00;
        tick();
        irqIn = 8'h08;
        ticks(6);
        setMask(8'hFF);
        ticks(2);
        if (cpuReq) begin
            ack();
            ret();
        end
        tick();
        setMask(8'h00);
        irqIn = 8'h00;
        ticks(4);
        total++; if (pending !== 8'h08) $display("FAIL held_long: got %h want 08", pending); else passed++;
        ticks(6);
        total++; if (pending !== 8'h08 || cpuReq !== 1'b0) $display("FAIL held_once: got %h/%b want 08/0", pending, cpuReq); else passed++;
        setMask(8'hFF);
        tick();
        total++; if ({cpuReq, irqId} !== {1'b1, 3'd3}) $display("FAIL held_req: got %b/%0d want 1/3", cpuReq, irqId); else passed++;
        ack();
        ret();
        ticks(6);
        total++; if ({cpuReq, pending} !== 9'h0) $display("FAIL held_norearm: got %b/%h want 0/00", cpuReq, pending); else passed++;
    endtask

    task automatic test_reset_mid_service();
        fall(8'h20);
        ticks(4);
        ack();
        total++; if (inService !== 8'h20) $display("FAIL midrst_svc: got %h want 20", inService); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({cpuReq, irqId, irqVector, irqMask, pending, inService} !== 36'h0) $display("FAIL midrst_clear: got %b/%0d/%h/%h/%h/%h want all 0", cpuReq, irqId, irqVector, irqMask, pending, inService); else passed++;
        tick();
        rst = 1'b0;
        setMask(8'hFF);
        fall(8'h20);
        ticks(4);
        total++; if ({cpuReq, irqId, irqVector} !== {1'b1, 3'd5, 8'h94}) $display("FAIL midrst_serve: got %b/%0d/%h want 1/5/94", cpuReq, irqId, irqVector); else passed++;
        ack();
        ret();
        tick();
    endtask

    task automatic test_nesting();
        fall(8'h20);
        ticks(4);
        ack();
        fall(8'h80);
        ticks(5);
`ifdef INT_NESTING_EN
        total++; if ({cpuReq, irqId} !== {1'b1, 3'd7}) $display("FAIL nest_req: got %b/%0d want 1/7", cpuReq, irqId); else passed++;
        ack();
        total++; if ({cpuReq, inService} !== {1'b0, 8'hA0}) $display("FAIL nest_ack: got %b/%h want 0/a0", cpuReq, inService); else passed++;
        ret();
        total++; if (inService !== 8'h20) $display("FAIL nest_pop1: got %h want 20", inService); else passed++;
        ret();
        tick();
        total++; if ({cpuReq, inService} !== 9'h0) $display("FAIL nest_pop2: got %b/%h want 0/00", cpuReq, inService); else passed++;
`else
        total++; if ({cpuReq, pending, inService} !== {1'b0, 8'h80, 8'h20}) $display("FAIL nonest_wait: got %b/%h/%h want 0/80/20", cpuReq, pending, inService); else passed++;
        ret();
        total++; if ({cpuReq, inService} !== 9'h0) $display("FAIL nonest_ret: got %b/%h want 0/00", cpuReq, inService); else passed++;
        tick();
        total++; if ({cpuReq, irqId} !== {1'b1, 3'd7}) $display("FAIL nonest_next: got %b/%0d want 1/7", cpuReq, irqId); else passed++;
        ack();
        ret();
        tick();
`endif
    endtask

    task automatic test_random();
        logic [7:0] modelPend, modelMask, b;
        int         id;
        modelPend = '0;
        for (int it = 0; it < 20; it++) begin
            irqIn     = 8'hFF;
            modelMask = 8'($urandom_range(0, 255));
            setMask(modelMask);
            ticks(4);
            for (int phase = 0; phase < 2; phase++) begin
                if (phase == 1) begin
                    b         = 8'($urandom_range(1, 255));
                    irqIn     = ~b;
                    modelPend = modelPend | b;
                    ticks(5);
                    total++; if (pending !== modelPend) $display("FAIL rnd_pend[%0d]: got %h want %h", it, pending, modelPend); else passed++;
                end
                for (int k = 0; k < 9; k++) begin
                    id = modelId(modelPend & modelMask);
                    if (id < 0) begin
                        total++; if (cpuReq !== 1'b0) $display("FAIL rnd_idle[%0d]: got cpuReq %b want 0", it, cpuReq); else passed++;
                        break;
                    end
                    total++; if ({cpuReq, irqId, irqVector} !== {1'b1, 3'(id), modelVec(id)}) $display("FAIL rnd_req[%0d]: got %b/%0d/%h want 1/%0d/%h", it, cpuReq, irqId, irqVector, id, modelVec(id)); else passed++;
                    ack();
                    modelPend[id] = 1'b0;
                    total++; if ({pending, inService} !== {modelPend, 8'(1 << id)}) $display("FAIL rnd_ack[%0d]: got %h/%h want %h/%h", it, pending, inService, modelPend, 8'(1 << id)); else passed++;
                    ret();
                    total++; if (inService !== 8'h00) $display("FAIL rnd_ret[%0d]: got %h want 00", it, inService); else passed++;
                    tick();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_req_hold();
        test_mask();
        test_held_reset();
        test_reset_mid_service();
        test_nesting();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
